// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn countdown timer driving connect4_fsm times_up
module turn_timer #(
    parameter int         CLK_FREQ          = 50_000_000,
    parameter int         TURN_SECS         = 10,
    parameter logic [2:0] PLAYER_TURN_STATE = 3'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       player_turn,
    input  logic       win_flag,
    output logic       times_up,
    output logic [6:0] secs_left,
    output logic       warn,
    output logic [1:0] timer_state,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam logic [6:0]    RELOAD    = 7'(TURN_SECS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2,
        HALTED  = 2'd3
    } tstate_t;

    tstate_t       cur, nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [6:0]    secs_nxt;
    logic          pulse_nxt;
    logic          prev_turn;
    logic          turn_change;
    logic          in_turn;
    logic          tick;
    logic [3:0]    tens_digit, ones_digit;

    assign turn_change = (player_turn != prev_turn);
    assign in_turn     = (state == PLAYER_TURN_STATE);
    assign tick        = (cur == RUNNING) && (presc == PRESC_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Rule order in RUNNING matters: win beats turn change beats leaving the
    // player-turn state beats the tick, so a final tick never pulses when
    // anything else happens on the same edge.
    always_comb begin
        nxt       = cur;
        secs_nxt  = secs_left;
        presc_nxt = presc;
        pulse_nxt = 1'b0;
        case (cur)
            IDLE: begin
                secs_nxt  = RELOAD;
                presc_nxt = '0;
                if (win_flag) begin
                    nxt = HALTED;
                end else if (in_turn) begin
                    nxt = RUNNING;
                end
            end
            RUNNING: begin
                if (win_flag) begin
                    nxt = HALTED;
                end else if (turn_change) begin
                    secs_nxt  = RELOAD;
                    presc_nxt = '0;
                end else if (!in_turn) begin
                    nxt       = IDLE;
                    secs_nxt  = RELOAD;
                    presc_nxt = '0;
                end else if (tick) begin
                    presc_nxt = '0;
                    if (secs_left == 7'd1) begin
                        secs_nxt  = 7'd0;
                        pulse_nxt = 1'b1;
                        nxt       = EXPIRED;
                    end else begin
                        secs_nxt = secs_left - 7'd1;
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            EXPIRED: begin
                secs_nxt = 7'd0;
                if (win_flag) begin
                    nxt = HALTED;
                end else if (turn_change || !in_turn) begin
                    nxt       = IDLE;
                    secs_nxt  = RELOAD;
                    presc_nxt = '0;
                end
            end
            HALTED: begin
                nxt = HALTED;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            secs_left <= RELOAD;
            presc     <= '0;
            times_up  <= 1'b0;
            prev_turn <= 1'b0;
        end else begin
            secs_left <= secs_nxt;
            presc     <= presc_nxt;
            times_up  <= pulse_nxt;
            prev_turn <= player_turn;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        timer_state = cur;
        warn        = (cur == RUNNING) && (secs_left >= 7'd1) && (secs_left <= 7'd3);
        tens_digit  = 4'(secs_left / 7'd10);
        ones_digit  = 4'(secs_left % 7'd10);
        seg_tens    = seg_decode(tens_digit);
        seg_ones    = seg_decode(ones_digit);
    end

endmodule

// File: tb/tb_turn_timer.sv
// tb/tb_turn_timer.sv - directed plus randomized check of turn_timer against a cycle-count model
module tb_turn_timer;

    localparam int CF = 4;
    localparam int TS = 3;
    localparam int P_IDLE = 0, P_RUN = 1, P_EXP = 2, P_HALT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state;
    logic       player_turn;
    logic       win_flag;
    logic       times_up;
    logic [6:0] secs_left;
    logic       warn;
    logic [1:0] timer_state;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    int n_assert = 0;
    int n_fail   = 0;

    int   m_phase;
    int   m_elapsed;
    int   m_frozen;
    logic m_prev;
    logic m_pulse;
    int   halted_cnt;

    logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    turn_timer #(.CLK_FREQ(CF), .TURN_SECS(TS), .PLAYER_TURN_STATE(3'd1)) dut (
        .clk(clk), .reset(reset), .state(state), .player_turn(player_turn),
        .win_flag(win_flag), .times_up(times_up), .secs_left(secs_left),
        .warn(warn), .timer_state(timer_state), .seg_tens(seg_tens), .seg_ones(seg_ones)
    );

    always #5 clk = ~clk;

    // Seconds remaining follow directly from how many uninterrupted running cycles have elapsed.
    function automatic int m_secs();
        case (m_phase)
            P_RUN:   return TS - m_elapsed / CF;
            P_EXP:   return 0;
            P_HALT:  return m_frozen;
            default: return TS;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_elapsed = 0; m_frozen = TS; m_prev = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_step();
        logic tc;
        tc = (player_turn != m_prev);
        m_prev = player_turn;
        m_pulse = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (win_flag) begin m_frozen = TS; m_phase = P_HALT; end
                else if (state == 3'd1) begin m_phase = P_RUN; m_elapsed = 0; end
            end
            P_RUN: begin
                if (win_flag) begin m_frozen = m_secs(); m_phase = P_HALT; end
                else if (tc) m_elapsed = 0;
                else if (state != 3'd1) m_phase = P_IDLE;
                else begin
                    m_elapsed++;
                    if (m_elapsed == TS * CF) begin m_phase = P_EXP; m_pulse = 1'b1; end
                end
            end
            P_EXP: begin
                if (win_flag) begin m_frozen = 0; m_phase = P_HALT; end
                else if (tc || state != 3'd1) m_phase = P_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_assert++;
        assert (got === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int s;
        s = m_secs();
        chk({tag, ".times_up"}, 32'(times_up), int'(m_pulse));
        chk({tag, ".secs_left"}, 32'(secs_left), s);
        chk({tag, ".warn"}, 32'(warn), (m_phase == P_RUN && s >= 1 && s <= 3) ? 1 : 0);
        chk({tag, ".timer_state"}, 32'(timer_state), m_phase);
        chk({tag, ".seg_tens"}, 32'(seg_tens), int'(seg_lut[s / 10]));
        chk({tag, ".seg_ones"}, 32'(seg_ones), int'(seg_lut[s % 10]));
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        if (m_phase == P_HALT) halted_cnt++; else halted_cnt = 0;
    endtask

    task automatic run(input int n, input string tag, output int pulses, output int first);
        pulses = 0; first = -1;
        for (int i = 1; i <= n; i++) begin
            cyc(tag);
            if (times_up === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    // Reset lands between clock edges; outputs must change before any edge arrives.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        halted_cnt = 0;
        check_all(tag);
        chk({tag, ".imm_state"}, 32'(timer_state), 0);
        chk({tag, ".imm_seg_ones"}, 32'(seg_ones), int'(7'b0110000));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int p, f;
        reset = 1'b1; state = 3'd0; player_turn = 1'b0; win_flag = 1'b0;
        halted_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.seg_tens", 32'(seg_tens), int'(7'b1000000));
        reset = 1'b0;

        state = 3'd1;
        cyc("enter");
        chk("enter.state", 32'(timer_state), 1);
        run(12, "count", p, f);
        chk("count.pulses", 32'(p), 1);
        chk("count.pulse_cycle", 32'(f), 12);
        chk("count.expired", 32'(timer_state), 2);

        run(40, "exp_wait", p, f);
        chk("exp_wait.no_repulse", 32'(p), 0);
        player_turn = ~player_turn;
        cyc("exp_toggle");
        chk("exp_toggle.idle", 32'(timer_state), 0);
        chk("exp_toggle.secs", 32'(secs_left), 3);
        cyc("reenter");
        chk("reenter.running", 32'(timer_state), 1);

        run(6, "pre_toggle", p, f);
        player_turn = ~player_turn;
        cyc("toggle");
        chk("toggle.reload", 32'(secs_left), 3);
        run(12, "post_toggle", p, f);
        chk("post_toggle.pulse_cycle", 32'(f), 12);
        chk("post_toggle.pulses", 32'(p), 1);

        state = 3'd2;
        cyc("leave");
        state = 3'd1;
        cyc("enter2");
        run(11, "pre_final", p, f);
        chk("pre_final.pulses", 32'(p), 0);
        state = 3'd2;
        cyc("final_exit");
        chk("final_exit.times_up", 32'(times_up), 0);
        chk("final_exit.state", 32'(timer_state), 0);
        chk("final_exit.secs", 32'(secs_left), 3);

        state = 3'd1;
        cyc("enter3");
        run(4, "pre_win", p, f);
        win_flag = 1'b1;
        cyc("win");
        chk("win.halted", 32'(timer_state), 3);
        chk("win.secs", 32'(secs_left), 2);
        run(50, "halted", p, f);
        chk("halted.pulses", 32'(p), 0);
        chk("halted.secs", 32'(secs_left), 2);
        async_reset("halt_reset");
        win_flag = 1'b0;

        cyc("enter4");
        run(5, "mid_run", p, f);
        async_reset("mid_reset");

        for (int i = 0; i < 800; i++) begin
            state = ($urandom_range(0, 99) < 85) ? 3'd1 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 4) player_turn = ~player_turn;
            win_flag = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 149) == 0 || halted_cnt > 15) begin
                win_flag = 1'b0;
                async_reset("rand_reset");
            end
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_timer.md
Name: turn_timer

Overview:
- Per-turn countdown timer that sits directly upstream of connect4_fsm and drives its times_up input.
- Watches the game FSM's state, player_turn and win_flag outputs.
- Restarts the countdown each turn and emits a one-cycle times_up pulse when a player's time runs out.
- Also provides seconds-remaining, warning and 7-segment outputs for the board display.

Parameters:
- CLK_FREQ, 50_000_000, clock cycles per second tick; must be ≥2.
- TURN_SECS, 10, seconds allowed per turn; legal range 1..99.
- PLAYER_TURN_STATE, 3'd1, encoding of the game FSM's PLAYER_TURN state.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; asynchronous, active-high.
- state  input  3  game FSM current state.
- player_turn  input  1  game FSM player indicator (0 = player 1, 1 = player 2).
- win_flag  input  1  game FSM win indication.
- times_up  output  1  one-cycle pulse to connect4_fsm when the turn expires.
- secs_left  output  7  seconds remaining, binary.
- warn  output  1  high in the last 3 seconds of a running turn.
- timer_state  output  2  internal FSM state: IDLE=0, RUNNING=1, EXPIRED=2, HALTED=3.
- seg_tens  output  7  tens digit of secs_left, active-low, bit order gfedcba.
- seg_ones  output  7  ones digit of secs_left, active-low, bit order gfedcba.

Behaviour:
- One clock, clk. reset is asynchronous, active-high.
- Reset values: timer_state=IDLE; secs_left=TURN_SECS; prescaler=0; times_up=0; warn=0; prev_turn register=0.
- seg outputs are combinational decodes of secs_left. With the default TURN_SECS=10, reset shows seg_tens=7'b1111001 and seg_ones=7'b1000000.
- Prescaler:
  - Counts 0..CLK_FREQ-1 only while in RUNNING.
  - tick = (prescaler == CLK_FREQ-1) while in RUNNING; the prescaler wraps to 0 on that tick.
  - The prescaler is cleared on every reload and on every entry to RUNNING.
- prev_turn register: samples player_turn every cycle. turn_change = (player_turn != prev_turn).
- IDLE:
  - Holds secs_left=TURN_SECS.
  - Goes to RUNNING when state==PLAYER_TURN_STATE and win_flag==0; the prescaler is 0 in the first RUNNING cycle.
  - Goes to HALTED if win_flag==1.
- RUNNING: each cycle, apply the first matching rule in priority order.
  1. win_flag=1 → HALTED; secs_left frozen; no pulse.
  2. turn_change → secs_left=TURN_SECS, prescaler=0, stay in RUNNING.
  3. state != PLAYER_TURN_STATE → IDLE; secs_left=TURN_SECS; no pulse.
  4. tick with secs_left==1 → secs_left=0, times_up=1 on the same edge, go to EXPIRED.
  5. tick otherwise → secs_left decrements by 1.
- EXPIRED:
  - secs_left holds 0 and times_up returns to 0.
  - win_flag → HALTED.
  - turn_change or state != PLAYER_TURN_STATE → IDLE with reload.
  - Never re-pulses while waiting.
- HALTED:
  - All outputs frozen except times_up, which is 0.
  - Exits only on reset.
- times_up:
  - Registered; exactly one cycle wide.
  - Asserted on the edge ending the TURN_SECS×CLK_FREQ-th consecutive uninterrupted RUNNING cycle.
- warn = (timer_state==RUNNING) && (1 ≤ secs_left ≤ 3). Combinational from registers.
- Simultaneous events:
  - Final tick in the same cycle as a state exit, turn change or win: the higher-priority rule wins, and times_up is not asserted.
  - Turn change in the same cycle as entering RUNNING from IDLE: a plain entry with reload; no extra effect.
- Reset mid-count: outputs go to reset values immediately, without waiting for a clock edge. A pending pulse is lost.
- Width rules:
  - secs_left is 7 bits.
  - Prescaler width is $clog2(CLK_FREQ).
  - BCD split is tens = secs_left/10 and ones = secs_left%10; a tens digit of 0 is displayed as 0, not blank.

Test Plan:
- Bench parameters: CLK_FREQ=4, TURN_SECS=3.
- Reset asserted mid-run, asynchronously between clock edges → outputs immediately show timer_state=0, secs_left=3, times_up=0, warn=0, seg_ones=7'b0110000.
- state=1 held, player_turn constant, win_flag=0 →
  - RUNNING one cycle later.
  - secs_left steps 3→2→1→0 every 4 cycles.
  - times_up high for exactly 1 cycle, 12 cycles after RUNNING entry.
  - timer_state=2; warn high throughout the run.
- Toggle player_turn 6 cycles into RUNNING → secs_left back to 3 the next cycle; times_up exactly 12 cycles after the toggle, not before.
- Drive state=2 in the same cycle as the final tick (cycle 12) → no times_up; timer_state=0; secs_left=3.
- win_flag=1 at cycle 5 of RUNNING → timer_state=3, secs_left frozen at 2, no times_up for 50 further cycles; a reset pulse returns to IDLE with secs_left=3.
- In EXPIRED, keep state=1 and player_turn constant for 40 cycles → no second pulse. Then toggle player_turn → IDLE, secs_left=3, RUNNING again on the next cycle.
